// File: rtl/regex_imem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction BRAM among NUM_CPUS
// fetch ports; up to two fetches in flight, one BRAM read per cycle.
module regex_imem_arbiter #(
    parameter int unsigned NUM_CPUS          = 4,
    parameter int unsigned CPU_ID_BITS       = 2,
    parameter int unsigned MEMORY_WIDTH      = 16,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11,
    parameter int unsigned BRAM_LATENCY      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CPUS-1:0]                   cpu_memory_valid,
    input  logic [NUM_CPUS*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr,
    output logic [NUM_CPUS-1:0]                   cpu_memory_ready,
    output logic [NUM_CPUS*MEMORY_WIDTH-1:0]      cpu_memory_data,
    output logic                                  bram_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]          bram_addr,
    input  logic [MEMORY_WIDTH-1:0]               bram_rdata,
    output logic [31:0]                           grant_count,
    output logic                                  busy
);

    if (BRAM_LATENCY != 1) begin : g_bad_latency
        $error("regex_imem_arbiter supports BRAM_LATENCY == 1 only");
    end
    if (NUM_CPUS != (1 << CPU_ID_BITS)) begin : g_bad_ids
        $error("NUM_CPUS must equal 2**CPU_ID_BITS");
    end

    logic [MEMORY_ADDR_WIDTH-1:0] addr_arr [NUM_CPUS];
    logic [MEMORY_WIDTH-1:0]      data_q   [NUM_CPUS];

    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_ports
        assign addr_arr[g] = cpu_memory_addr[g*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
        assign cpu_memory_data[g*MEMORY_WIDTH +: MEMORY_WIDTH] = data_q[g];
    end

    logic [NUM_CPUS-1:0]          pending_q, pending_d;
    logic [NUM_CPUS-1:0]          ready_q, ready_d;
    logic [CPU_ID_BITS-1:0]       rr_ptr_q;
    logic                         s1_valid_q;
    logic [CPU_ID_BITS-1:0]       s1_id_q;
    logic [MEMORY_ADDR_WIDTH-1:0] bram_addr_q;
    logic [31:0]                  grant_count_q;

    logic [NUM_CPUS-1:0]          eligible;
    logic                         grant_valid;
    logic                         gnt;
    logic [CPU_ID_BITS-1:0]       grant_id;

    assign eligible = cpu_memory_valid & ~pending_q;

    // First eligible port at or after rr_ptr; the id width wraps the scan for free.
    always_comb begin
        logic [CPU_ID_BITS-1:0] idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            idx = rr_ptr_q + CPU_ID_BITS'(k);
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Gated so the BRAM interface reads as idle while reset is held.
    assign gnt       = grant_valid & rst;
    assign bram_en   = gnt;
    assign bram_addr = gnt ? addr_arr[grant_id] : bram_addr_q;

    always_comb begin
        pending_d = pending_q & ~ready_q;
        if (gnt) begin
            pending_d[grant_id] = 1'b1;
        end
        ready_d = '0;
        if (s1_valid_q) begin
            ready_d[s1_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q     <= '0;
            ready_q       <= '0;
            rr_ptr_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_id_q       <= '0;
            bram_addr_q   <= '0;
            grant_count_q <= '0;
        end else begin
            pending_q  <= pending_d;
            ready_q    <= ready_d;
            s1_valid_q <= gnt;
            if (gnt) begin
                s1_id_q       <= grant_id;
                rr_ptr_q      <= grant_id + 1'b1;
                bram_addr_q   <= addr_arr[grant_id];
                grant_count_q <= grant_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CPUS; i++) begin
                data_q[i] <= '0;
            end
        end else if (s1_valid_q) begin
            data_q[s1_id_q] <= bram_rdata;
        end
    end

    assign cpu_memory_ready = ready_q;
    assign grant_count      = grant_count_q;
    assign busy             = |pending_q;

endmodule

// File: tb/tb_regex_imem_arbiter.sv
// Randomized and directed bench for regex_imem_arbiter against a cycle-indexed
// behavioural model of grants, completions and per-port data.
module tb_regex_imem_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      cpu_memory_valid = '0;
    logic [N*AW-1:0]   cpu_memory_addr = '0;
    logic [N-1:0]      cpu_memory_ready;
    logic [N*DW-1:0]   cpu_memory_data;
    logic              bram_en;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_rdata = '0;
    logic [31:0]       grant_count;
    logic              busy;

    regex_imem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_memory_valid (cpu_memory_valid),
        .cpu_memory_addr  (cpu_memory_addr),
        .cpu_memory_ready (cpu_memory_ready),
        .cpu_memory_data  (cpu_memory_data),
        .bram_en          (bram_en),
        .bram_addr        (bram_addr),
        .bram_rdata       (bram_rdata),
        .grant_count      (grant_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];

    int checks = 0;
    int failures = 0;

    // Model: a port granted in cycle g is busy through g+2 and completes in g+2.
    int            cyc;
    int            last_grant [N];
    int            ptr;
    logic [31:0]   cnt;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] exp_data [N];
    bit            comp_v  [4];
    int            comp_id [4];
    logic [DW-1:0] comp_d  [4];
    int            grants_seen [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            last_grant[i] = -100;
            exp_data[i]   = '0;
        end
        for (int s = 0; s < 4; s++) comp_v[s] = 1'b0;
        ptr = 0;
        cnt = '0;
        last_addr = '0;
    endtask

    function automatic logic [N*DW-1:0] pack_data();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = exp_data[i];
        return r;
    endfunction

    // Called at negedge: applies inputs, checks the cycle, advances to next negedge.
    task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a);
        int            g;
        int            slot;
        logic [N-1:0]  exp_ready;
        logic          exp_busy;
        logic [AW-1:0] exp_addr;
        cpu_memory_valid = v;
        cpu_memory_addr  = a;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (g < 0 && v[i] && cyc >= last_grant[i] + 3) g = i;
        end
        exp_addr = (g >= 0) ? a[g*AW +: AW] : last_addr;
        slot = cyc % 4;
        exp_ready = '0;
        if (comp_v[slot]) begin
            exp_ready[comp_id[slot]] = 1'b1;
            exp_data[comp_id[slot]]  = comp_d[slot];
            comp_v[slot] = 1'b0;
        end
        exp_busy = 1'b0;
        for (int i = 0; i < N; i++)
            if (cyc >= last_grant[i] + 1 && cyc <= last_grant[i] + 2) exp_busy = 1'b1;
        check("bram_en", 64'(bram_en), 64'(g >= 0));
        check("bram_addr", 64'(bram_addr), 64'(exp_addr));
        check("ready", 64'(cpu_memory_ready), 64'(exp_ready));
        check("data", 64'(cpu_memory_data), 64'(pack_data()));
        check("grant_count", 64'(grant_count), 64'(cnt));
        check("busy", 64'(busy), 64'(exp_busy));
        if (g >= 0) begin
            last_grant[g] = cyc;
            ptr = (g + 1) % N;
            cnt = cnt + 32'd1;
            last_addr = exp_addr;
            comp_v[(cyc + 2) % 4]  = 1'b1;
            comp_id[(cyc + 2) % 4] = g;
            comp_d[(cyc + 2) % 4]  = mem[exp_addr];
            grants_seen[g]++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        cpu_memory_valid = '0;
        #1;
        model_reset();
        check("rst_ready", 64'(cpu_memory_ready), 64'd0);
        check("rst_data", 64'(cpu_memory_data), 64'd0);
        check("rst_en", 64'(bram_en), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_count", 64'(grant_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [N*AW-1:0] addrs(input int a0, input int a1, input int a2,
                                              input int a3);
        logic [N*AW-1:0] r;
        r = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return r;
    endfunction

    initial begin
        logic [N*AW-1:0] ra;
        int g0;
        int g3;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[11'h005] = {8'h03, 8'h20};  // SPLIT, target 0x20
        for (int i = 0; i < N; i++) grants_seen[i] = 0;
        cyc = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single CPU fetch; valid dropped on the completion edge.
        step(4'b0100, addrs(0, 0, 5, 0));
        step(4'b0100, addrs(0, 0, 5, 0));
        step(4'b0000, addrs(0, 0, 5, 0));
        check("split_word", 64'(cpu_memory_data[2*DW +: DW]), 64'(16'h0320));
        step(4'b0000, '0);

        // All four at once from a known pointer.
        apply_reset();
        for (int t = 0; t < 3; t++) step(4'b1111, addrs('h10, 'h11, 'h12, 'h13));
        step(4'b1000, addrs('h10, 'h11, 'h12, 'h13));
        for (int t = 0; t < 3; t++) step(4'b0000, '0);
        check("all4_grants", 64'(grant_count), 64'd4);
        check("all4_slice3", 64'(cpu_memory_data[3*DW +: DW]), 64'(mem['h13]));

        // Two continuous requesters share fairly.
        g0 = grants_seen[0];
        g3 = grants_seen[3];
        for (int t = 0; t < 40; t++) step(4'b1001, addrs($urandom, 0, 0, $urandom));
        check("fair_cpu0", 64'(grants_seen[0] - g0 >= 12), 64'd1);
        check("fair_cpu3", 64'(grants_seen[3] - g3 >= 12), 64'd1);
        for (int t = 0; t < 3; t++) step(4'b0000, '0);

        // CPU1 withdraws while CPU0 wins.
        apply_reset();
        step(4'b0011, addrs('h40, 'h41, 0, 0));
        for (int t = 0; t < 3; t++) step(4'b0000, '0);
        check("withdraw_slice1", 64'(cpu_memory_data[1*DW +: DW]), 64'd0);

        // Reset mid-fetch: no completion for CPU1 after release.
        step(4'b0010, addrs(0, 'h77, 0, 0));
        apply_reset();
        for (int t = 0; t < 3; t++) step(4'b0000, '0);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < N; i++) ra[i*AW +: AW] = AW'($urandom);
            step(N'($urandom), ra);
        end
        for (int t = 0; t < 3; t++) step(4'b0000, '0);

        // Counter wrap.
        dut.grant_count_q = 32'hFFFF_FFFF;
        cnt = 32'hFFFF_FFFF;
        step(4'b0001, addrs('h9, 0, 0, 0));
        step(4'b0000, '0);
        check("wrap", 64'(grant_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regex_imem_arbiter.md
Name: regex_imem_arbiter

Overview:
- Shares one single-port instruction BRAM among NUM_CPUS regex_cpu_pipelined instances.
- Each CPU sees the standard fetch handshake: memory_valid/memory_addr out, memory_ready/memory_data in.
- Arbitration is round-robin with up to two fetches in flight. Throughput is one BRAM read per cycle across different CPUs.
- Sits between the CPU array and the instruction memory inside the regex core.

Parameters:
- NUM_CPUS, 4, number of requesting CPUs (power of 2, ≥2)
- CPU_ID_BITS, 2, log2(NUM_CPUS)
- MEMORY_WIDTH, 16, instruction word width
- MEMORY_ADDR_WIDTH, 11, instruction address width
- BRAM_LATENCY, 1, BRAM read latency in cycles (fixed at 1 for this revision)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cpu_memory_valid  in  NUM_CPUS  per-CPU fetch request
- cpu_memory_addr  in  NUM_CPUS*MEMORY_ADDR_WIDTH  per-CPU fetch address; slice i = [i*AW +: AW]
- cpu_memory_ready  out  NUM_CPUS  per-CPU one-cycle completion pulse
- cpu_memory_data  out  NUM_CPUS*MEMORY_WIDTH  per-CPU fetched word
- bram_en  out  1  BRAM read enable
- bram_addr  out  MEMORY_ADDR_WIDTH  BRAM read address
- bram_rdata  in  MEMORY_WIDTH  BRAM read data, valid the cycle after bram_en
- grant_count  out  32  total grants since reset; wraps
- busy  out  1  at least one fetch in flight or completing

Behaviour:
- Reset (rst=0, asynchronous):
  - cpu_memory_ready=0, cpu_memory_data=0, bram_en=0, bram_addr=0.
  - grant_count=0, busy=0, rr_ptr=0, all in-flight state cleared.
  - Fetches in flight at reset are dropped; no ready pulse is issued for them after reset release.
- Eligibility in cycle T: cpu_memory_valid[i]=1 and pending[i]=0.
- pending[i] is set from the grant edge until the end of port i's ready cycle.
- Grant (cycle T, combinational from registered state):
  - Select the first eligible i scanning rr_ptr, rr_ptr+1, … modulo NUM_CPUS.
  - Drive bram_en=1 and bram_addr=cpu_memory_addr[i] combinationally.
  - If none eligible: bram_en=0; bram_addr holds its last granted value.
- On the grant edge:
  - pending[i]<=1, rr_ptr<=(i+1) mod NUM_CPUS.
  - grant_count<=grant_count+1 (32-bit wrap).
  - Stage-1 register <= {valid=1, id=i}.
- Cycle T+1: bram_rdata is valid for the stage-1 id. At the edge:
  - cpu_memory_data slice[id] <= bram_rdata.
  - cpu_memory_ready[id] <= 1.
- Cycle T+2:
  - cpu_memory_ready[id]=1 for exactly one cycle, with the data slice already stable.
  - pending[id] clears at the end of T+2.
  - The earliest re-grant to the same CPU is T+3. The requester drops or changes valid at the T+2 edge.
- Latency: request sampled at T → ready and data at T+2. Another CPU may be granted at T+1, so back-to-back grants to different CPUs are allowed every cycle.
- Data slices are registered. A slice holds its last fetched word until that CPU's next completion; other slices are untouched.
- At most one ready bit is set per cycle (one completion per cycle).
- Requesters must hold addr stable while valid=1 and unserved. The arbiter samples addr only in the grant cycle.
- A request withdrawn before grant is simply not served; no error.
- busy = any pending bit set.
- Starvation bound: a continuously requesting CPU is granted within NUM_CPUS cycles of becoming eligible.

Test Plan:
- Reset: assert rst=0 mid-fetch (CPU1 granted, ready not yet issued) → all outputs 0 immediately; no cpu_memory_ready[1] after rst returns high; grant_count=0.
- Single CPU: CPU2 valid, addr 0x005; BRAM model returns {SPLIT,8'h20} → bram_en/addr=0x005 at T; ready[2]=1 only at T+2 with slice2={SPLIT,8'h20}; no re-grant before T+3.
- All four CPUs valid at T0, rr_ptr=0, addrs 0x10/0x11/0x12/0x13 → grants at T0..T3 in order 0,1,2,3; ready pulses at T2..T5, each slice carrying mem[0x10..0x13].
- Round-robin fairness: CPUs 0 and 3 hold valid continuously for 40 cycles → grants alternate, each CPU served every ≤3 cycles; grant_count increments once per grant; no two ready bits high in the same cycle.
- Withdrawn request: CPU1 raises valid for one cycle while CPU0 is being granted, then drops it → CPU1 is never granted; bram_en only for CPU0; CPU1's slice is unchanged.
- Counter wrap: force grant_count to 0xFFFFFFFF (via hierarchical deposit), then one grant → grant_count=0.
